ex_multicycle_unit: RTL
=======================

Name: ex_multicycle_unit

Overview:
- Execute-stage consumer of the decode/execute register outputs; sits directly downstream of the D/E pipeline buffer.
- Captures operands and function code for multi-cycle ops: unsigned 16x16 multiply and unsigned 16/16 divide.
- Runs an iterative 16-step datapath, using shift-add for multiply and restoring division for divide.
- Drives a stall back to fetch/decode so the D/E buffer holds the next instruction until the result is produced.

Parameters:
- WIDTH, 16, operand width; iteration count equals WIDTH.
- FUNC_MUL, 4'b1000, function code selecting multiply.
- FUNC_DIV, 4'b1001, function code selecting divide.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  multi-cycle control bit from the D/E control-signal bus.
- function_in  input  4  function field from the D/E buffer.
- readData1_in  input  16  operand A: multiplicand or dividend.
- readData2_in  input  16  operand B: multiplier or divisor.
- writeAdd_in  input  3  destination register address.
- stall  output  1  hold request to PC and D/E buffer.
- result_valid  output  1  one-cycle pulse; result fields are valid.
- result_lo  output  16  product[15:0] or quotient.
- result_hi  output  16  product[31:16] or remainder.
- writeAdd_out  output  3  destination address carried with the result.
- div_by_zero  output  1  set together with result_valid when a divide had divisor 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, iteration counter=0.
  - All internal operand and accumulator registers are 0.
  - result_valid=0, div_by_zero=0, result_lo=0, result_hi=0, writeAdd_out=0.
  - stall=0.
- States:
  - IDLE: accept a new operation.
  - BUSY: iterate.
  - DONE: present the result for one cycle.
- Accept condition: state is IDLE or DONE, start=1, and function_in equals FUNC_MUL or FUNC_DIV.
  - On the accepting edge, capture A, B, op, and writeAdd_in; clear the counter; go to BUSY.
  - start=1 with any other function_in is ignored: no state change, stall stays low.
- BUSY:
  - Each edge performs one iteration and increments the counter.
  - On the edge where counter reaches WIDTH-1: register the outputs, go to DONE.
  - BUSY therefore lasts exactly 16 cycles.
- DONE:
  - result_valid=1 for exactly this one cycle.
  - Next state is BUSY if the accept condition holds; otherwise IDLE.
- Latency: result_valid is high in the 17th cycle after the cycle in which start was accepted.
- stall is combinational:
  - 1 when state=BUSY.
  - 1 in IDLE/DONE when the accept condition holds.
  - 0 otherwise; in particular 0 during DONE unless a new op is being accepted.
- Multiply:
  - 32-bit unsigned product, formed with an LSB-first shift-add over 16 steps.
  - result_hi:result_lo = A*B.
  - div_by_zero=0.
- Divide:
  - Restoring division, MSB-first; remainder register is 17 bits wide.
  - result_lo = quotient, result_hi = remainder.
  - Divisor 0 is not special-cased in the datapath. It naturally yields quotient 16'hFFFF and remainder = A; div_by_zero=1 is flagged alongside.
- result_lo, result_hi and writeAdd_out hold their values after DONE until the next DONE or reset. div_by_zero likewise holds.
- Upstream contract: the D/E buffer must not advance while stall=1. Inputs are sampled only on the accepting edge; input changes during BUSY have no effect.
- Reset during BUSY or DONE:
  - Immediate return to IDLE.
  - The in-flight operation is discarded; no result_valid pulse.
  - stall drops asynchronously with rst.

Test Plan:
- MUL A=3, B=5, dest=2 -> stall high for 17 cycles (start cycle plus 16 BUSY cycles); result_valid pulses once at cycle 17; lo=0x000F, hi=0x0000, writeAdd_out=2.
- MUL A=0xFFFF, B=0xFFFF -> hi=0xFFFE, lo=0x0001, div_by_zero=0.
- DIV A=100, B=7 -> lo=0x000E, hi=0x0002, div_by_zero=0; DIV A=0x8000, B=0x0003 -> lo=0x2AAA, hi=0x0002.
- DIV A=5, B=0 -> lo=0xFFFF, hi=0x0005, div_by_zero=1 with result_valid.
- Back-to-back: second MUL (A=2, B=4) presented in the DONE cycle of the first -> accepted with no idle gap; two result_valid pulses exactly 17 cycles apart; second lo=0x0008.
- rst asserted at BUSY iteration 7, then a start with function_in=4'b0000 -> outputs zero, no result_valid ever; stall stays 0; the non-multicycle start leaves state in IDLE.

Source files
------------

// File: rtl/ex_multicycle_unit.sv
// Execute-stage multi-cycle unit: unsigned WIDTHxWIDTH multiply (LSB-first
// shift-add) and unsigned WIDTH/WIDTH divide (MSB-first restoring), one
// iteration per clock. It stalls fetch/decode while it works.
//
// Handshake: an op is accepted on a rising edge when the unit is IDLE or DONE,
// start=1 and function_in is FUNC_MUL or FUNC_DIV. stall is high in that same
// cycle and for every BUSY cycle. The upstream D/E buffer therefore holds the
// next instruction until the unit reaches DONE. result_valid is a single-cycle
// pulse in DONE. The result fields keep their values until the next DONE.
module ex_multicycle_unit #(
    parameter int         WIDTH    = 16,
    parameter logic [3:0] FUNC_MUL = 4'b1000,
    parameter logic [3:0] FUNC_DIV = 4'b1001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       function_in,
    input  logic [WIDTH-1:0] readData1_in,
    input  logic [WIDTH-1:0] readData2_in,
    input  logic [2:0]       writeAdd_in,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       writeAdd_out,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]   shreg_q, shreg_d;     // mul: multiplier; div: dividend -> quotient
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [2:0]         dest_q, dest_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [2:0]         wa_q, wa_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quot_step;

    // Accept decode and one iteration of each datapath
    always_comb begin
        accept    = (state_q != S_BUSY) && start &&
                    ((function_in == FUNC_MUL) || (function_in == FUNC_DIV));
        prod_step = shreg_q[0] ? (prod_q + mcand_q) : prod_q;
        rem_shift = {rem_q[WIDTH-1:0], shreg_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
        // A negative trial difference means the divisor did not fit: restore
        rem_step  = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
        quot_step = {shreg_q[WIDTH-2:0], ~trial[WIDTH+1]};
    end

    // Next-state, operand capture, iteration and result registration
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        mcand_d   = mcand_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        dest_d    = dest_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        wa_d      = wa_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    is_div_d  = (function_in == FUNC_DIV);
                    mcand_d   = {{WIDTH{1'b0}}, readData1_in};
                    shreg_d   = (function_in == FUNC_DIV) ? readData1_in : readData2_in;
                    divisor_d = readData2_in;
                    prod_d    = '0;
                    rem_d     = '0;
                    dest_d    = writeAdd_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    shreg_d = quot_step;
                    rem_d   = rem_step;
                end else begin
                    prod_d  = prod_step;
                    mcand_d = mcand_q << 1;
                    shreg_d = shreg_q >> 1;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    lo_d    = is_div_q ? quot_step : prod_step[WIDTH-1:0];
                    hi_d    = is_div_q ? rem_step[WIDTH-1:0] : prod_step[2*WIDTH-1:WIDTH];
                    wa_d    = dest_q;
                    dbz_d   = is_div_q && (divisor_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            mcand_q   <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            dest_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            wa_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            mcand_q   <= mcand_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            dest_q    <= dest_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            wa_q      <= wa_d;
            dbz_q     <= dbz_d;
        end
    end

    // Outputs: stall covers BUSY plus the accepting cycle
    always_comb begin
        stall        = (state_q == S_BUSY) || accept;
        result_valid = (state_q == S_DONE);
        result_lo    = lo_q;
        result_hi    = hi_q;
        writeAdd_out = wa_q;
        div_by_zero  = dbz_q;
    end

endmodule
